// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: settle, gate-count, handshake out.
// Optional AUTO mode sweeps consecutive oscillators, one result each.
module ro_meas_ctrl #(
  parameter int N_RO       = 8,
  parameter int SEL_W      = 3,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [SEL_W-1:0] SEL,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic             AUTO,
  input  logic [N_RO-1:0]  RO_IN,
  output logic [N_RO-1:0]  RO_EN,
  output logic             BUSY,
  output logic             VALID,
  input  logic             READY,
  output logic [CNT_W-1:0] RESULT,
  output logic [SEL_W-1:0] RESULT_SEL,
  output logic             OVF
);

  localparam int SC_W = $clog2(SETTLE_CYC + 1);
  localparam int TW   = (WIN_W > SC_W) ? WIN_W : SC_W;
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(N_RO - 1);
  localparam logic [TW-1:0]    SET_LD = TW'(SETTLE_CYC - 1);
  localparam logic [N_RO-1:0]  ONE    = N_RO'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    HOLD
  } state_t;

  state_t           state, nstate;
  logic [SEL_W-1:0] idx, nidx;
  logic [SEL_W-1:0] sel_c;
  logic [WIN_W-1:0] win;
  logic             auto_q;
  logic [TW-1:0]    tmr, ntmr;
  logic             tmr_z;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic             cnt_ovf;
  logic             vld;
  logic             xfer;

  assign sel_c = (int'(SEL) >= N_RO) ? LAST : SEL;
  assign tmr_z = (tmr == '0);
  assign xfer  = vld & READY;
  assign rise  = s2 & ~s3;
  assign BUSY  = (state != IDLE);
  assign VALID = vld;

  always_comb begin
    nstate = state;
    nidx   = idx;
    ntmr   = tmr;
    unique case (state)
      IDLE: begin
        if (START) begin
          nstate = SETTLE;
          nidx   = sel_c;
          ntmr   = SET_LD;
        end
      end
      SETTLE: begin
        if (tmr_z) begin
          nstate = (win == '0) ? HOLD : GATE;
          ntmr   = TW'(win) - TW'(1);
        end else begin
          ntmr = tmr - TW'(1);
        end
      end
      GATE: begin
        if (tmr_z) nstate = HOLD;
        else       ntmr   = tmr - TW'(1);
      end
      HOLD: begin
        if (xfer) begin
          if (auto_q && idx < LAST) begin
            nstate = SETTLE;
            nidx   = idx + SEL_W'(1);
            ntmr   = SET_LD;
          end else begin
            nstate = IDLE;
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
      tmr   <= '0;
      RO_EN <= '0;
    end else begin
      state <= nstate;
      idx   <= nidx;
      tmr   <= ntmr;
      RO_EN <= (nstate == SETTLE || nstate == GATE)
               ? (ONE << nidx) : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      win    <= '0;
      auto_q <= 1'b0;
    end else if (state == IDLE && START) begin
      win    <= WINDOW;
      auto_q <= AUTO;
    end
  end

  // Sync chain refills with the new oscillator during SETTLE (>= 3 cycles).
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= RO_IN[idx];
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      cnt_ovf <= 1'b0;
    end else if (state == SETTLE) begin
      cnt     <= '0;
      cnt_ovf <= 1'b0;
    end else if (state == GATE && rise) begin
      if (&cnt) cnt_ovf <= 1'b1;
      else      cnt     <= cnt + CNT_W'(1);
    end
  end

  // Result regs load on the first HOLD cycle and stay put until the next.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld        <= 1'b0;
      RESULT     <= '0;
      RESULT_SEL <= '0;
      OVF        <= 1'b0;
    end else if (state == HOLD && !vld) begin
      vld        <= 1'b1;
      RESULT     <= cnt;
      RESULT_SEL <= idx;
      OVF        <= cnt_ovf;
    end else if (xfer) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl with a result scoreboard.
// Second instance covers 8-bit saturation and index clamping.
module tb_ro_meas_ctrl;

  localparam int S = 16;

  typedef struct {
    logic [2:0] sel;
    int         cnt;
    int         tol;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        start = 1'b0;
  logic [2:0]  sel   = '0;
  logic [15:0] win   = '0;
  logic        au    = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  ro_in;
  logic [7:0]  ro_en;
  logic        busy, valid, ovf;
  logic [15:0] result;
  logic [2:0]  rsel;

  logic        s_start = 1'b0;
  logic [2:0]  s_sel   = '0;
  logic [15:0] s_win   = '0;
  logic        s_auto  = 1'b0;
  logic        s_ready = 1'b0;
  logic [5:0]  s_ro;
  logic [5:0]  s_ro_en;
  logic        s_busy, s_valid, s_ovf;
  logic [7:0]  s_result;
  logic [2:0]  s_rsel;

  logic       slow = 1'b0;
  logic       fast = 1'b0;
  logic [7:0] slow_m = '0;
  logic [7:0] fast_m = '0;
  initial begin #3; forever #40 slow = ~slow; end
  initial begin #3; forever #20 fast = ~fast; end
  assign ro_in = (slow_m & {8{slow}}) | (fast_m & {8{fast}});
  assign s_ro  = {6{slow}};

  ro_meas_ctrl u_dut (
    .CLK(clk), .RST(rst), .START(start), .SEL(sel),
    .WINDOW(win), .AUTO(au), .RO_IN(ro_in), .RO_EN(ro_en),
    .BUSY(busy), .VALID(valid), .READY(ready),
    .RESULT(result), .RESULT_SEL(rsel), .OVF(ovf)
  );

  ro_meas_ctrl #(.N_RO(6), .CNT_W(8)) u_small (
    .CLK(clk), .RST(rst), .START(s_start), .SEL(s_sel),
    .WINDOW(s_win), .AUTO(s_auto), .RO_IN(s_ro), .RO_EN(s_ro_en),
    .BUSY(s_busy), .VALID(s_valid), .READY(s_ready),
    .RESULT(s_result), .RESULT_SEL(s_rsel), .OVF(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs,
                         input int exp, input int tol);
    total++;
    assert (!$isunknown(obs) && int'(obs) >= exp - tol
            && int'(obs) <= exp + tol) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit sm, input logic [2:0] s,
                    input logic [15:0] w, input logic a);
    if (sm) begin
      s_sel = s; s_win = w; s_start = 1'b1;
    end else begin
      sel = s; win = w; au = a; start = 1'b1;
    end
    step();
    start = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic wait_valid(input bit sm, output int n);
    n = 0;
    while ((sm ? s_valid : valid) !== 1'b1 && n < 20000) begin
      step();
      n++;
    end
  endtask

  task automatic push(input logic [2:0] s, input int c,
                      input int t, input logic o);
    exp_t e;
    e.sel = s; e.cnt = c; e.tol = t; e.ovf = o;
    q.push_back(e);
  endtask

  task automatic take(input bit sm, input string tag);
    exp_t e;
    chk({tag, "_vld"}, 32'(sm ? s_valid : valid), 1);
    chk({tag, "_pend"}, 32'(q.size() > 0), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_sel"}, 32'(sm ? s_rsel : rsel), 32'(e.sel));
      chk_rng({tag, "_res"},
              sm ? 32'(s_result) : 32'(result), e.cnt, e.tol);
      chk({tag, "_ovf"}, 32'(sm ? s_ovf : ovf), 32'(e.ovf));
      chk({tag, "_roen"}, sm ? 32'(s_ro_en) : 32'(ro_en), 0);
    end
    if (sm) s_ready = 1'b1;
    else    ready   = 1'b1;
    step();
    ready = 1'b0;
    s_ready = 1'b0;
    chk({tag, "_drop"}, 32'(sm ? s_valid : valid), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_roen"}, 32'(ro_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_vld"}, 32'(valid), 0);
    chk({tag, "_res"}, 32'(result), 0);
    chk({tag, "_rsel"}, 32'(rsel), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  initial begin
    int n;
    logic [15:0] r0;

    repeat (3) step();
    chk_reset("rst");
    chk("rst_s_vld", 32'(s_valid), 0);
    chk("rst_s_busy", 32'(s_busy), 0);
    rst = 1'b0;
    step();

    // single run, period 8 on oscillator 2
    slow_m = 8'h04;
    push(3'd2, 100, 1, 1'b0);
    go(0, 3'd2, 16'd800, 1'b0);
    chk("t1_roen_settle", 32'(ro_en), 32'h04);
    chk("t1_busy", 32'(busy), 1);
    repeat (S + 5) step();
    chk("t1_roen_gate", 32'(ro_en), 32'h04);
    wait_valid(0, n);
    chk("t1_lat", 32'(n + S + 5), 817);
    take(0, "t1");
    chk("t1_idle", 32'(busy), 0);
    repeat (3) step();
    chk_rng("t1_keep", 32'(result), 100, 1);

    // backpressure, isolation, ignored START
    fast_m = 8'hFB;
    push(3'd2, 100, 1, 1'b0);
    go(0, 3'd2, 16'd800, 1'b0);
    wait_valid(0, n);
    chk("t2_lat", 32'(n), 817);
    r0 = result;
    for (int i = 0; i < 20; i++) begin
      sel = 3'd0;
      au = 1'b1;
      start = i[0];
      chk("bp_vld", 32'(valid), 1);
      chk("bp_res", 32'(result), 32'(r0));
      chk("bp_roen", 32'(ro_en), 0);
      step();
    end
    start = 1'b0;
    au = 1'b0;
    take(0, "t2");
    chk("t2_idle", 32'(busy), 0);
    fast_m = 8'h00;

    // AUTO sweep from 5
    slow_m = 8'hFF;
    push(3'd5, 10, 1, 1'b0);
    push(3'd6, 10, 1, 1'b0);
    push(3'd7, 10, 1, 1'b0);
    go(0, 3'd5, 16'd80, 1'b1);
    au = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(0, n);
      if (k == 0) chk("t3_lat", 32'(n), 97);
      take(0, "t3");
      chk("t3_busy", 32'(busy), 32'(k < 2));
    end

    // zero window
    push(3'd3, 0, 0, 1'b0);
    go(0, 3'd3, 16'd0, 1'b0);
    wait_valid(0, n);
    chk("w0_lat", 32'(n), 17);
    take(0, "w0");
    chk("w0_idle", 32'(busy), 0);

    // 8-bit counter saturation, recovery, index clamp
    push(3'd0, 255, 0, 1'b1);
    go(1, 3'd0, 16'd4000, 1'b0);
    wait_valid(1, n);
    chk("sat_lat", 32'(n), 4017);
    take(1, "sat");
    push(3'd0, 10, 1, 1'b0);
    go(1, 3'd0, 16'd80, 1'b0);
    wait_valid(1, n);
    take(1, "nosat");
    push(3'd5, 0, 0, 1'b0);
    go(1, 3'd7, 16'd0, 1'b0);
    wait_valid(1, n);
    chk("clamp_lat", 32'(n), 17);
    take(1, "clamp");

    // reset mid-GATE, then fresh run
    slow_m = 8'h02;
    go(0, 3'd1, 16'd800, 1'b0);
    repeat (S + 100) step();
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("mid");
    push(3'd1, 100, 1, 1'b0);
    go(0, 3'd1, 16'd800, 1'b0);
    wait_valid(0, n);
    chk("re_lat", 32'(n), 817);
    take(0, "re");
    chk("re_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
